alu_accum_core: RTL and testbench
=================================

# alu_accum_core

Parametrised, registered ALU with an accumulator, a valid/ready handshake on both sides and a multi-cycle shift-add multiplier. It generalises the team's combinational 8-bit adder to a WIDTH-bit, eight-operation datapath. It sits behind the tile's pin wrapper, which maps ui_in/uio_in onto operands and uo_out onto the result.

## Interface
- WIDTH, 8, operand/result width in bits; legal values are powers of two from 4 to 32.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  core can accept a request.
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- acc_sel  input  1  1 = operand A is the accumulator, not port a.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- carry  output  1  carry, borrow or multiply-overflow flag.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (ADD/SUB only).
- busy  output  1  multiply in progress.

## Operation
- State machine:
  - IDLE, MUL and HOLD.
  - IDLE to HOLD on accept of a non-MUL op.
  - IDLE to MUL on accept of MUL.
  - MUL to HOLD when the iteration count reaches WIDTH.
  - HOLD to IDLE on out_ready. HOLD with out_ready and in_valid both high accepts the new op in the same cycle.
- Handshake and registers:
  - in_ready = (state==IDLE) or (state==HOLD and out_ready). It is combinational, with no dependence on in_valid.
  - Accept = in_valid and in_ready. op, the effective A, and b are captured at accept.
  - out_valid = (state==HOLD). result and all flags stay stable while out_valid is high and out_ready is low.
  - busy = (state==MUL).
- Arithmetic is modulo 2^WIDTH.
- ADD:
  - carry = carry-out of A+B.
  - overflow = sign(A)==sign(B) and sign(result)!=sign(A).
- SUB:
  - carry = borrow (A<B unsigned).
  - overflow = sign(A)!=sign(B) and sign(result)!=sign(A).
- AND, OR, XOR: carry=0, overflow=0.
- SHL and SHR:
  - The shift amount is b[log2(WIDTH)-1:0]; upper bits of b are ignored. Fill is zeros.
  - carry = last bit shifted out, or 0 when the amount is 0. overflow=0.
- MUL:
  - Unsigned shift-add, one multiplier bit per cycle, using a 2*WIDTH-bit partial product.
  - result = low WIDTH bits of the product. carry = OR of the high WIDTH bits. overflow=0.
- zero = (result==0) for every op.
- Accumulator:
  - WIDTH-bit register, loaded with result on every transition into HOLD.
  - acc_sel samples its value at accept, so back-to-back ops chain through it.
- in_valid is ignored while in MUL. An op arriving then is not lost: it waits until in_ready.
- Reset (asynchronous, any state including mid-MUL):
  - state=IDLE; result, flags, accumulator, partial product and counter cleared.
  - Outputs during reset: out_valid=0, busy=0, result=0, carry=0, zero=0, overflow=0, in_ready=1.
  - An aborted multiply produces no output.

## Timing
- Non-MUL ops:
  - Accept at edge N puts out_valid high, with result valid, from edge N onward.
  - That is one cycle of latency.
  - Back-to-back throughput of 1 op/cycle when out_ready is held high.
- MUL:
  - Accept at edge N gives busy high after edge N.
  - out_valid is high after edge N+WIDTH; latency is WIDTH cycles. busy falls on the same edge.
  - No new op is accepted until the MUL result handshake.
- zero is registered alongside result; there is no combinational path from a/b to outputs.
- The only combinational input-to-output path is out_ready to in_ready.

## Test plan
- ADD a=200 b=100 (WIDTH=8) -> result 44, carry 1, overflow 0, zero 0, out_valid one cycle after accept. ADD 100+100 -> 200, carry 0, overflow 1.
- SUB a=5 b=7 -> result 254, carry 1, overflow 0. SUB 128-1 -> 127, overflow 1. SHL a=0x81 b=0x09 (shift 1) -> 0x02, carry 1.
- MUL 15*17 -> 255, carry 0, out_valid exactly 8 cycles after accept, busy high for those 8 cycles. MUL 16*16 -> 0, zero 1, carry 1.
- Accumulator chain: ADD a=3 b=4 -> 7, then ADD acc_sel=1 b=5 -> 12, then XOR acc_sel=1 b=12 -> 0 with zero 1. Run with out_ready held high, expecting three results on consecutive cycles.
- Backpressure: hold out_ready low for 3 cycles after an ADD result -> result and flags unchanged, in_ready low. Raise out_ready with in_valid high -> the new op is accepted on that edge.
- Reset mid-MUL: assert rst 3 cycles into MUL 9*9 -> all outputs 0 immediately, in_ready 1. After release, a fresh ADD 1+1 -> 2 with normal latency, and no stale MUL result appears.

Source files
------------

// File: rtl/alu_accum_core.sv
// Registered WIDTH-bit ALU with accumulator, valid/ready handshake on both sides
// and a shift-add multiplier that retires one multiplier bit per cycle.
module alu_accum_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_t;

  state_t             r_state, w_nextState;
  logic [WIDTH-1:0]   r_result, r_acc, r_mplier;
  logic               r_carry, r_zero, r_ovf;
  logic [2*WIDTH-1:0] r_prod, r_mcand;
  logic [CW-1:0]      r_cnt;

  logic               w_accept, w_mulLast, w_isMul;
  logic [WIDTH-1:0]   w_opA, w_aluRes;
  logic               w_aluCarry, w_aluOvf;
  logic [WIDTH:0]     w_sum, w_diff, w_shl, w_shr;
  logic [SW-1:0]      w_shamt;
  logic [2*WIDTH-1:0] w_prodNext;

  assign w_accept   = in_valid & in_ready;
  assign w_isMul    = (op == OP_MUL);
  assign w_opA      = acc_sel ? r_acc : a;
  assign w_shamt    = b[SW-1:0];
  assign w_sum      = {1'b0, w_opA} + {1'b0, b};
  assign w_diff     = {1'b0, w_opA} - {1'b0, b};
  // The extra bit on each side of the shifters catches the last bit shifted out.
  assign w_shl      = {1'b0, w_opA} << w_shamt;
  assign w_shr      = {w_opA, 1'b0} >> w_shamt;
  assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mulLast  = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = w_isMul ? S_MUL : S_HOLD;
      end
      S_MUL: begin
        busy = 1'b1;
        if (w_mulLast) w_nextState = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_nextState = in_valid ? (w_isMul ? S_MUL : S_HOLD) : S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_aluRes   = '0;
    w_aluCarry = 1'b0;
    w_aluOvf   = 1'b0;
    case (op)
      OP_ADD: begin
        w_aluRes   = w_sum[WIDTH-1:0];
        w_aluCarry = w_sum[WIDTH];
        w_aluOvf   = (w_opA[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != w_opA[WIDTH-1]);
      end
      OP_SUB: begin
        w_aluRes   = w_diff[WIDTH-1:0];
        w_aluCarry = w_diff[WIDTH];
        w_aluOvf   = (w_opA[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != w_opA[WIDTH-1]);
      end
      OP_AND: w_aluRes = w_opA & b;
      OP_OR:  w_aluRes = w_opA | b;
      OP_XOR: w_aluRes = w_opA ^ b;
      OP_SHL: begin
        w_aluRes   = w_shl[WIDTH-1:0];
        w_aluCarry = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_aluRes   = w_shr[WIDTH:1];
        w_aluCarry = w_shr[0];
      end
      default: w_aluRes = '0;
    endcase
  end

  // The multiplicand shifts left while the multiplier shifts right, so each
  // cycle only needs to test bit 0 of the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      if (w_isMul) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_opA};
        r_mplier <= b;
        r_prod   <= '0;
        r_cnt    <= '0;
      end else begin
        r_result <= w_aluRes;
        r_carry  <= w_aluCarry;
        r_zero   <= (w_aluRes == '0);
        r_ovf    <= w_aluOvf;
        r_acc    <= w_aluRes;
      end
    end else if (r_state == S_MUL) begin
      r_prod   <= w_prodNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_mulLast) begin
        r_result <= w_prodNext[WIDTH-1:0];
        r_carry  <= |w_prodNext[2*WIDTH-1:WIDTH];
        r_zero   <= (w_prodNext[WIDTH-1:0] == '0);
        r_ovf    <= 1'b0;
        r_acc    <= w_prodNext[WIDTH-1:0];
      end
    end
  end

  assign result   = r_result;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_alu_accum_core.sv
// Directed self-checking bench for alu_accum_core at WIDTH=8.
module tb_alu_accum_core;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, XOR_ = 3'b100;
  localparam logic [2:0] SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

  logic       clk, rst, in_valid, in_ready, acc_sel, out_valid, out_ready;
  logic       carry, zero, overflow, busy;
  logic [2:0] op;
  logic [7:0] a, b, result;
  int total = 0;
  int bad   = 0;

  alu_accum_core #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_sel(acc_sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .overflow(overflow), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one request for a single edge; caller sits 1ns after a rising edge.
  task automatic issue(input logic [2:0] o, input logic s, input logic [7:0] x, input logic [7:0] y);
    op = o; acc_sel = s; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({out_valid, busy, result, carry, zero, overflow, in_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL reset_outputs: got %h want %h", {out_valid, busy, result, carry, zero, overflow, in_ready}, 14'h0001);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++; $display("[TB] FAIL idle_after_reset: got %b want 00", {out_valid, busy});
    end
  endtask

  task automatic test_add();
    issue(ADD, 1'b0, 8'd200, 8'd100);
    total++;
    if ({out_valid, result, carry, zero, overflow} !== {1'b1, 8'd44, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL add_200_100: got v=%b r=%0d c=%b z=%b o=%b want v=1 r=44 c=1 z=0 o=0", out_valid, result, carry, zero, overflow);
    end
    issue(ADD, 1'b0, 8'd100, 8'd100);
    total++;
    if ({out_valid, result, carry, zero, overflow} !== {1'b1, 8'd200, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL add_100_100: got v=%b r=%0d c=%b z=%b o=%b want v=1 r=200 c=0 z=0 o=1", out_valid, result, carry, zero, overflow);
    end
  endtask

  task automatic test_sub_logic_shift();
    issue(SUB, 1'b0, 8'd5, 8'd7);
    total++;
    if ({result, carry, overflow} !== {8'd254, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL sub_5_7: got r=%0d c=%b o=%b want r=254 c=1 o=0", result, carry, overflow);
    end
    issue(SUB, 1'b0, 8'd128, 8'd1);
    total++;
    if ({result, carry, overflow} !== {8'd127, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL sub_128_1: got r=%0d c=%b o=%b want r=127 c=0 o=1", result, carry, overflow);
    end
    issue(SHL, 1'b0, 8'h81, 8'h09);
    total++;
    if ({result, carry, overflow} !== {8'h02, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL shl_81_9: got r=%h c=%b o=%b want r=02 c=1 o=0", result, carry, overflow);
    end
    issue(SHR, 1'b0, 8'h81, 8'h01);
    total++;
    if ({result, carry} !== {8'h40, 1'b1}) begin
      bad++; $display("[TB] FAIL shr_81_1: got r=%h c=%b want r=40 c=1", result, carry);
    end
    issue(SHL, 1'b0, 8'h81, 8'h08);
    total++;
    if ({result, carry} !== {8'h81, 1'b0}) begin
      bad++; $display("[TB] FAIL shl_amount0: got r=%h c=%b want r=81 c=0", result, carry);
    end
    issue(AND_, 1'b0, 8'hF0, 8'h3C);
    total++;
    if ({result, carry, zero, overflow} !== {8'h30, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL and_f0_3c: got r=%h c=%b z=%b o=%b want r=30 c=0 z=0 o=0", result, carry, zero, overflow);
    end
  endtask

  task automatic test_mul();
    issue(MUL, 1'b0, 8'd15, 8'd17);
    for (int i = 1; i <= 8; i++) begin
      total++;
      if ({busy, out_valid, in_ready} !== 3'b100) begin
        bad++; $display("[TB] FAIL mul_busy_cycle%0d: got b/v/r=%b want 100", i, {busy, out_valid, in_ready});
      end
      @(posedge clk); #1;
    end
    total++;
    if ({out_valid, busy, result, carry, zero} !== {1'b1, 1'b0, 8'd255, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL mul_15_17: got v=%b b=%b r=%0d c=%b z=%b want v=1 b=0 r=255 c=0 z=0", out_valid, busy, result, carry, zero);
    end
    issue(MUL, 1'b0, 8'd16, 8'd16);
    repeat (8) begin @(posedge clk); #1; end
    total++;
    if ({out_valid, result, carry, zero, overflow} !== {1'b1, 8'd0, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL mul_16_16: got v=%b r=%0d c=%b z=%b o=%b want v=1 r=0 c=1 z=1 o=0", out_valid, result, carry, zero, overflow);
    end
  endtask

  task automatic test_accum_chain();
    op = ADD; acc_sel = 1'b0; a = 8'd3; b = 8'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, result} !== {1'b1, 8'd7}) begin
      bad++; $display("[TB] FAIL chain_step1: got v=%b r=%0d want v=1 r=7", out_valid, result);
    end
    op = ADD; acc_sel = 1'b1; a = 8'd99; b = 8'd5;
    @(posedge clk); #1;
    total++;
    if ({out_valid, result} !== {1'b1, 8'd12}) begin
      bad++; $display("[TB] FAIL chain_step2: got v=%b r=%0d want v=1 r=12", out_valid, result);
    end
    op = XOR_; acc_sel = 1'b1; a = 8'd99; b = 8'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, result, zero} !== {1'b1, 8'd0, 1'b1}) begin
      bad++; $display("[TB] FAIL chain_step3: got v=%b r=%0d z=%b want v=1 r=0 z=1", out_valid, result, zero);
    end
  endtask

  task automatic test_backpressure();
    issue(ADD, 1'b0, 8'd200, 8'd100);
    out_ready = 1'b0;
    op = SUB; acc_sel = 1'b0; a = 8'd5; b = 8'd7; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, result, carry, zero, overflow} !== {1'b1, 1'b0, 8'd44, 1'b1, 1'b0, 1'b0}) begin
        bad++; $display("[TB] FAIL stall_cycle%0d: got v=%b rdy=%b r=%0d c=%b z=%b o=%b want v=1 rdy=0 r=44 c=1 z=0 o=0", i, out_valid, in_ready, result, carry, zero, overflow);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL ready_follows_out_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, result, carry} !== {1'b1, 8'd254, 1'b1}) begin
      bad++; $display("[TB] FAIL accept_on_release: got v=%b r=%0d c=%b want v=1 r=254 c=1", out_valid, result, carry);
    end
  endtask

  task automatic test_back_to_back();
    issue(MUL, 1'b0, 8'd3, 8'd5);
    op = ADD; acc_sel = 1'b0; a = 8'd1; b = 8'd2; in_valid = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    total++;
    if ({out_valid, result} !== {1'b1, 8'd15}) begin
      bad++; $display("[TB] FAIL mul_then_pending: got v=%b r=%0d want v=1 r=15", out_valid, result);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, result} !== {1'b1, 8'd3}) begin
      bad++; $display("[TB] FAIL pending_add: got v=%b r=%0d want v=1 r=3", out_valid, result);
    end
  endtask

  task automatic test_reset_mid_mul();
    int staleSeen;
    issue(MUL, 1'b0, 8'd9, 8'd9);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, result, carry, zero, overflow, in_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL reset_mid_mul: got %h want %h", {out_valid, busy, result, carry, zero, overflow, in_ready}, 14'h0001);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    staleSeen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) staleSeen++;
    end
    total++;
    if (staleSeen != 0) begin
      bad++; $display("[TB] FAIL no_stale_mul: got %0d active cycles want 0", staleSeen);
    end
    issue(ADD, 1'b1, 8'd77, 8'd0);
    total++;
    if ({out_valid, result, zero} !== {1'b1, 8'd0, 1'b1}) begin
      bad++; $display("[TB] FAIL acc_cleared: got v=%b r=%0d z=%b want v=1 r=0 z=1", out_valid, result, zero);
    end
    issue(ADD, 1'b0, 8'd1, 8'd1);
    total++;
    if ({out_valid, result, carry, zero} !== {1'b1, 8'd2, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL add_after_reset: got v=%b r=%0d c=%b z=%b want v=1 r=2 c=0 z=0", out_valid, result, carry, zero);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'b000; acc_sel = 1'b0; a = 8'h00; b = 8'h00;
    test_reset();
    test_add();
    test_sub_logic_shift();
    test_mul();
    test_accum_chain();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
